// File: rtl/aud_rec_writer.sv
`default_nettype none
// ============================================================================
//  Module   : aud_rec_writer
//  Purpose  : Writes the recorder sample stream sequentially into the external
//             SRAM with a timed active-low write-enable pulse. It tracks the
//             length of the take and absorbs one early sample in a skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module aud_rec_writer #(
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 16,
    parameter int                WE_CYCLES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_rec_en,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we_n,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_full,
    output logic              o_overrun
);

    localparam int              CNT_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_PAUSE = 3'd4,
        S_FULL  = 3'd5
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    we_cnt, we_cnt_nx;
    logic [DATA_W-1:0]   buf_data, buf_data_nx;
    logic                buf_full, buf_full_nx;
    logic                pause_pend, pause_pend_nx;
    logic                stop_pend, stop_pend_nx;
    logic                rec_en_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                we_n_nx;
    logic [ADDR_W-1:0]   end_addr_nx;
    logic                full_nx;
    logic                overrun_nx;
    logic                stop_eff;
    logic                pause_eff;

    // State and registered outputs; reset forces WE high immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            we_cnt      <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            pause_pend  <= 1'b0;
            stop_pend   <= 1'b0;
            o_rec_en    <= 1'b0;
            o_sram_addr <= '0;
            o_sram_data <= '0;
            o_sram_we_n <= 1'b1;
            o_end_addr  <= '0;
            o_full      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_nx;
            we_cnt      <= we_cnt_nx;
            buf_data    <= buf_data_nx;
            buf_full    <= buf_full_nx;
            pause_pend  <= pause_pend_nx;
            stop_pend   <= stop_pend_nx;
            o_rec_en    <= rec_en_nx;
            o_sram_addr <= addr_nx;
            o_sram_data <= data_nx;
            o_sram_we_n <= we_n_nx;
            o_end_addr  <= end_addr_nx;
            o_full      <= full_nx;
            o_overrun   <= overrun_nx;
        end
    end

    // Next-state and next-output logic; stop beats pause beats start
    always_comb begin
        state_nx      = state;
        we_cnt_nx     = we_cnt;
        buf_data_nx   = buf_data;
        buf_full_nx   = buf_full;
        pause_pend_nx = pause_pend;
        stop_pend_nx  = stop_pend;
        rec_en_nx     = o_rec_en;
        addr_nx       = o_sram_addr;
        data_nx       = o_sram_data;
        we_n_nx       = o_sram_we_n;
        end_addr_nx   = o_end_addr;
        full_nx       = o_full;
        overrun_nx    = o_overrun;
        stop_eff      = stop_pend | i_stop;
        pause_eff     = pause_pend | i_pause;

        // A sample arriving while the writer is busy and the skid slot is
        // taken is lost; flag it for the whole take.
        if ((state == S_WRITE || state == S_HOLD) && i_valid && buf_full) begin
            overrun_nx = 1'b1;
        end

        case (state)
            S_IDLE: begin
                rec_en_nx = 1'b0;
                if (i_start && !i_stop && !i_pause) begin
                    addr_nx       = '0;
                    end_addr_nx   = '0;
                    overrun_nx    = 1'b0;
                    buf_full_nx   = 1'b0;
                    pause_pend_nx = 1'b0;
                    stop_pend_nx  = 1'b0;
                    rec_en_nx     = 1'b1;
                    state_nx      = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_stop) begin
                    state_nx  = S_IDLE;
                    rec_en_nx = 1'b0;
                    addr_nx   = '0;
                end else if (i_pause) begin
                    state_nx  = S_PAUSE;
                    rec_en_nx = 1'b0;
                end else if (i_valid) begin
                    data_nx   = i_data;
                    we_n_nx   = 1'b0;
                    we_cnt_nx = '0;
                    state_nx  = S_WRITE;
                end
            end

            S_WRITE: begin
                if (i_valid && !buf_full) begin
                    buf_data_nx = i_data;
                    buf_full_nx = 1'b1;
                end
                if (i_stop) begin
                    stop_pend_nx = 1'b1;
                end else if (i_pause) begin
                    pause_pend_nx = 1'b1;
                end
                if (we_cnt == CNT_LAST) begin
                    we_n_nx  = 1'b1;
                    state_nx = S_HOLD;
                end else begin
                    we_cnt_nx = we_cnt + CNT_W'(1);
                end
            end

            S_HOLD: begin
                // Wraps to 0 only if the whole array is written and MAX_ADDR
                // is the top of the address space.
                end_addr_nx = o_sram_addr + ADDR_W'(1);
                if (stop_eff) begin
                    state_nx      = S_IDLE;
                    rec_en_nx     = 1'b0;
                    full_nx       = 1'b0;
                    addr_nx       = '0;
                    buf_full_nx   = 1'b0;
                    pause_pend_nx = 1'b0;
                    stop_pend_nx  = 1'b0;
                end else if (o_sram_addr == MAX_ADDR) begin
                    state_nx      = S_FULL;
                    rec_en_nx     = 1'b0;
                    full_nx       = 1'b1;
                    buf_full_nx   = 1'b0;
                    pause_pend_nx = 1'b0;
                end else begin
                    addr_nx = o_sram_addr + ADDR_W'(1);
                    if (buf_full) begin
                        data_nx       = buf_data;
                        buf_full_nx   = 1'b0;
                        we_n_nx       = 1'b0;
                        we_cnt_nx     = '0;
                        pause_pend_nx = pause_eff;
                        state_nx      = S_WRITE;
                    end else if (i_valid) begin
                        // Slot is free this cycle: the new sample goes
                        // straight out instead of parking in the buffer.
                        data_nx       = i_data;
                        we_n_nx       = 1'b0;
                        we_cnt_nx     = '0;
                        pause_pend_nx = pause_eff;
                        state_nx      = S_WRITE;
                    end else if (pause_eff) begin
                        pause_pend_nx = 1'b0;
                        rec_en_nx     = 1'b0;
                        state_nx      = S_PAUSE;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end

            S_PAUSE: begin
                if (i_stop) begin
                    state_nx  = S_IDLE;
                    rec_en_nx = 1'b0;
                    addr_nx   = '0;
                end else if (!i_pause && i_start) begin
                    rec_en_nx = 1'b1;
                    state_nx  = S_WAIT;
                end
            end

            S_FULL: begin
                if (i_stop) begin
                    state_nx  = S_IDLE;
                    rec_en_nx = 1'b0;
                    full_nx   = 1'b0;
                    addr_nx   = '0;
                end
            end

            default: begin
                state_nx  = S_IDLE;
                rec_en_nx = 1'b0;
                we_n_nx   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire
